// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared types and default widths for the memory request
// controller and its response skid buffer.
//   rsp_state_e        : response slot state (EMPTY / BYPASS / HOLD)
//   DEFAULT_DATA_WIDTH : default data bus width
//   DEFAULT_ADDR_WIDTH : default word-address width (1024 words)
//   TXN_COUNT_W        : width of the accepted-request counter
package mem_req_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int TXN_COUNT_W        = 16;

  typedef enum logic [1:0] {
    RSP_EMPTY  = 2'd0,  // nothing pending
    RSP_BYPASS = 2'd1,  // response data is live on the memory read port
    RSP_HOLD   = 2'd2   // response data parked in the hold register
  } rsp_state_e;

endpackage

// File: rtl/rsp_skid_buf.sv
// rsp_skid_buf: single-entry response slot with a bypass path straight from
// the memory's registered read data and a hold register used when the
// consumer stalls.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   push               : a response-producing request was accepted this edge
//   push_wr            : that request is a write acknowledge (data = push_wdata)
//   push_wdata         : write data to echo back for a write acknowledge
//   mem_rd_data        : registered read data from the memory port
//   rsp_ready          : consumer ready
//   rsp_valid/rsp_rdata: response output
//   in_ready           : slot can take a new request this cycle
//   busy               : a response is pending
module rsp_skid_buf
  import mem_req_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  push_wr,
  input  logic [DATA_WIDTH-1:0] push_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  rsp_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  in_ready,
  output logic                  busy
);

  rsp_state_e            state;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  wr_sel_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;
  logic [DATA_WIDTH-1:0] bypass_data;

  // Stage p1: the cycle after acceptance; memory read data or the echoed
  // write data is live here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_sel_p1 <= 1'b0;
    end else if (push) begin
      wr_sel_p1 <= push_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (push && push_wr) begin
      wdata_p1 <= push_wdata;
    end
  end

  assign bypass_data = wr_sel_p1 ? wdata_p1 : mem_rd_data;

  // No push can coincide with a stall in BYPASS or with HOLD, because
  // in_ready is low in both of those situations.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RSP_EMPTY;
      hold_q <= '0;
    end else begin
      case (state)
        RSP_EMPTY: begin
          if (push) state <= RSP_BYPASS;
        end
        RSP_BYPASS: begin
          if (!rsp_ready) begin
            state  <= RSP_HOLD;
            hold_q <= bypass_data;
          end else if (!push) begin
            state <= RSP_EMPTY;
          end
        end
        RSP_HOLD: begin
          if (rsp_ready) state <= RSP_EMPTY;
        end
        default: state <= RSP_EMPTY;
      endcase
    end
  end

  assign rsp_valid = (state != RSP_EMPTY);
  assign busy      = rsp_valid;
  assign rsp_rdata = (state == RSP_HOLD) ? hold_q : bypass_data;
  // Gated by reset_n so nothing is offered or accepted while reset is held.
  assign in_ready  = reset_n &&
                     ((state == RSP_EMPTY) || ((state == RSP_BYPASS) && rsp_ready));

endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: valid/ready request front end for one port of a synchronous
// memory, returning read responses in order through rsp_skid_buf.
// Optional feature: define MEM_REQ_CTRL_WRACK_EN to make every accepted write
// produce a response carrying the written data; otherwise writes are posted.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   req_valid/req_ready           : request handshake
//   req_we, req_addr, req_wdata   : request kind, word address, write data
//   rsp_valid/rsp_ready, rsp_rdata: response handshake and data
//   mem_wr_en, mem_addr, mem_wr_data : memory port drive
//   mem_rd_data                   : memory registered read data
//   busy                          : an accepted request still owes a response
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy
);

  logic                   accept;
  logic                   push;
  logic                   push_wr;
  logic [TXN_COUNT_W-1:0] txn_count;

  // Stage p0: request acceptance; the memory port is driven directly.
  assign accept      = req_valid && req_ready;
  assign mem_addr    = req_addr;
  assign mem_wr_data = req_wdata;
  assign mem_wr_en   = accept && req_we;

`ifdef MEM_REQ_CTRL_WRACK_EN
  assign push    = accept;
  assign push_wr = accept && req_we;
`else
  assign push    = accept && !req_we;
  assign push_wr = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txn_count <= '0;
    end else if (accept) begin
      txn_count <= txn_count + 16'd1;
    end
  end

  rsp_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (push),
    .push_wr     (push_wr),
    .push_wdata  (req_wdata),
    .mem_rd_data (mem_rd_data),
    .rsp_ready   (rsp_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .in_ready    (req_ready),
    .busy        (busy)
  );

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed bench for mem_req_ctrl with a behavioural
// synchronous memory and a response scoreboard.
module tb_mem_req_ctrl;
  import mem_req_pkg::*;

`ifdef MEM_REQ_CTRL_WRACK_EN
  localparam bit WRACK = 1'b1;
`else
  localparam bit WRACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [9:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_rdata;
  logic        mem_wr_en;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wr_data, mem_rd_data;
  logic        busy;

  logic [15:0] mem [0:1023];
  logic [15:0] sb[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_txn;
  int          waited;

  mem_req_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory, registered read (old data on a same-edge write).
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every taken response is compared against the scoreboard head.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got 0x%0h expected no response", rsp_rdata);
      end else begin
        chk("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, sb.pop_front()});
        pop_cyc.push_back(cyc);
      end
    end
  end

  // One request; returns at #1 after the accepting edge with req_valid still high.
  task automatic xfer(input logic we, input logic [9:0] a, input logic [15:0] d,
                      input logic [15:0] exp, output int wt);
    bit ok;
    ok = 1'b0;
    wt = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        if (!we || WRACK) sb.push_back(we ? d : exp);
        exp_txn = exp_txn + 16'd1;
        chk("mem_wr_en", {31'b0, mem_wr_en}, {31'b0, we});
        break;
      end
      wt++;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL req_timeout: got req_ready=0 for 20 cycles expected acceptance");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_txn = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_txn   = '0;
    reset_n   = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 10'd4;
    req_wdata = 16'h7777;
    rsp_ready = 1'b1;

    // Reset state with a write request being offered.
    @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_req_ready", {31'b0, req_ready}, 0);
    chk("rst_mem_wr_en", {31'b0, mem_wr_en}, 0);
    chk("rst_busy",      {31'b0, busy}, 0);
    chk("rst_txn",       {16'b0, dut.txn_count}, 0);
    chk("rst_hold",      {16'b0, dut.u_skid.hold_q}, 0);
    chk("rst_state",     32'(dut.u_skid.state), 32'(RSP_EMPTY));
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    req_valid = 1'b0;

    // Preload through the DUT.
    xfer(1'b1, 10'd1, 16'h00A1, 16'h0, waited);
    xfer(1'b1, 10'd2, 16'h00A2, 16'h0, waited);
    xfer(1'b1, 10'd3, 16'h00A3, 16'h0, waited);
    xfer(1'b1, 10'd7, 16'hBEEF, 16'h0, waited);
    idle(3);

    // Write then read the same address on consecutive edges.
    xfer(1'b1, 10'd5, 16'h1234, 16'h0, waited);
    xfer(1'b0, 10'd5, 16'h0, 16'h1234, waited);
    req_valid = 1'b0;
    @(negedge clk);
    chk("raw_rsp_valid", {31'b0, rsp_valid}, 1);
    @(posedge clk);
    #1;
    idle(2);

    // Back-to-back reads.
    xfer(1'b0, 10'd1, 16'h0, 16'h00A1, waited);
    chk("b2b_ready0", waited, 0);
    xfer(1'b0, 10'd2, 16'h0, 16'h00A2, waited);
    chk("b2b_ready1", waited, 0);
    xfer(1'b0, 10'd3, 16'h0, 16'h00A3, waited);
    chk("b2b_ready2", waited, 0);
    idle(3);
    n = pop_cyc.size();
    chk("b2b_gap1", pop_cyc[n-2] - pop_cyc[n-3], 1);
    chk("b2b_gap2", pop_cyc[n-1] - pop_cyc[n-2], 1);

    // Stalled read goes to HOLD while the address keeps moving.
    rsp_ready = 1'b0;
    xfer(1'b0, 10'd7, 16'h0, 16'hBEEF, waited);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr = 10'(20 + i);
      @(negedge clk);
      chk("hold_rsp_valid", {31'b0, rsp_valid}, 1);
      chk("hold_req_ready", {31'b0, req_ready}, 0);
      chk("hold_rdata",     {16'b0, rsp_rdata}, 32'h0000BEEF);
      @(posedge clk);
      #1;
    end
    chk("hold_state", 32'(dut.u_skid.state), 32'(RSP_HOLD));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("hold_done_valid", {31'b0, rsp_valid}, 0);
    chk("hold_done_busy",  {31'b0, busy}, 0);
    @(posedge clk);
    #1;

    // Reset pulse while a read sits in BYPASS.
    rsp_ready = 1'b0;
    xfer(1'b0, 10'd2, 16'h0, 16'h00A2, waited);
    req_valid = 1'b0;
    chk("pre_rst_state", 32'(dut.u_skid.state), 32'(RSP_BYPASS));
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("midrst_busy",      {31'b0, busy}, 0);
    chk("midrst_txn",       {16'b0, dut.txn_count}, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    exp_txn   = '0;
    repeat (4) begin
      @(negedge clk);
      chk("postrst_rsp_valid", {31'b0, rsp_valid}, 0);
    end
    @(posedge clk);
    #1;

    // Write acknowledge present or absent depending on build.
    xfer(1'b1, 10'd9, 16'h5A5A, 16'h0, waited);
    req_valid = 1'b0;
    @(negedge clk);
    chk("wr_rsp_valid", {31'b0, rsp_valid}, {31'b0, WRACK});
    chk("wr_busy",      {31'b0, busy}, {31'b0, WRACK});
    @(negedge clk);
    chk("wr_rsp_gone",  {31'b0, rsp_valid}, 0);
    @(posedge clk);
    #1;
    chk("txn_after_wr", {16'b0, dut.txn_count}, {16'b0, exp_txn});

    // Counter wrap after 65536 accepted requests from reset.
    pulse_reset();
    chk("wrap_start", {16'b0, dut.txn_count}, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      xfer(1'b1, 10'd0, i[15:0], 16'h0, waited);
      if (i == 65534) chk("wrap_ffff", {16'b0, dut.txn_count}, 32'h0000FFFF);
    end
    req_valid = 1'b0;
    chk("wrap_zero", {16'b0, dut.txn_count}, 0);
    idle(4);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the data bus width.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set the word-address width (1024-word memory).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid / req_ready  input / output  1 / 1  SHALL be the request handshake.
REQ-006 req_we  input  1  SHALL select write (1) or read (0).
REQ-007 req_addr / req_wdata  input  ADDR_WIDTH / DATA_WIDTH  SHALL carry the request address and write data.
REQ-008 rsp_valid / rsp_ready  output / input  1 / 1  SHALL be the response handshake.
REQ-009 rsp_rdata  output  DATA_WIDTH  SHALL carry the response data.
REQ-010 mem_wr_en, mem_addr, mem_wr_data  output  1, ADDR_WIDTH, DATA_WIDTH  SHALL drive one port of the synchronous memory.
REQ-011 mem_rd_data  input  DATA_WIDTH  SHALL be that port's registered read data.
REQ-012 busy  output  1  SHALL be high while any accepted request has not yet completed its response.

Function
REQ-013 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-014 mem_addr SHALL equal req_addr and mem_wr_data SHALL equal req_wdata combinationally.
REQ-015 mem_wr_en SHALL equal req_valid && req_ready && req_we.
REQ-016 A read accepted at edge N SHALL raise rsp_valid in cycle N+1, with rsp_rdata = mem_rd_data (bypass path).
REQ-017 If rsp_ready is low in cycle N+1, mem_rd_data SHALL be captured into a hold register at edge N+1, and rsp_rdata SHALL come from that register until the response is taken.
REQ-018 Response states SHALL be: EMPTY (nothing pending), BYPASS (in-flight read, data on mem_rd_data) and HOLD (data in hold register).
REQ-019 Transitions:
  - EMPTY->BYPASS on an accepted read.
  - BYPASS->BYPASS on rsp_ready && accepted read.
  - BYPASS->EMPTY on rsp_ready with no accepted read.
  - BYPASS->HOLD on !rsp_ready.
  - HOLD->EMPTY on rsp_ready.
REQ-020 req_ready SHALL be high in EMPTY, high in BYPASS only when rsp_ready is high, and low in HOLD.
REQ-021 Maximum throughput SHALL be one request per cycle; at most one read SHALL be outstanding beyond the response slot.
REQ-022 Responses SHALL be returned strictly in request order; no response SHALL be dropped or duplicated.
REQ-023 A write SHALL complete in its acceptance cycle and SHALL NOT change response state unless REQ-028 applies.
REQ-024 Read-after-write to the same address on consecutive edges SHALL return the newly written data.
REQ-025 A 16-bit wrapping counter txn_count (internal, observable in simulation) SHALL increment on each accepted request and wrap 0xFFFF->0x0000.

Reset
REQ-026 While reset_n is low:
  - response state SHALL be EMPTY.
  - rsp_valid, req_ready, mem_wr_en and busy SHALL be 0.
  - the hold register and txn_count SHALL be 0.
REQ-027 Reset asserted mid-transaction SHALL discard any pending response; no rsp_valid SHALL appear for it after release.

Configuration
REQ-028 With MEM_REQ_CTRL_WRACK_EN defined:
  - each accepted write SHALL produce a response one cycle later, with rsp_rdata = written data.
  - that response SHALL follow the same state machine and ordering as reads.
  Without MEM_REQ_CTRL_WRACK_EN, writes SHALL be posted and produce no response.

Structure
REQ-029 Package mem_req_pkg SHALL hold the response-state enum and the default DATA_WIDTH and ADDR_WIDTH constants.
REQ-030 The bypass/hold logic SHALL be a sub-module rsp_skid_buf, instantiated once.

Verification
REQ-031 Write 0x1234 to addr 5, then read addr 5 on the next edge -> rsp_valid one cycle after the read is accepted, rsp_rdata=0x1234.
REQ-032 Back-to-back reads of addrs 1,2,3 (data 0xA1,0xA2,0xA3) with rsp_ready=1 -> responses 0xA1,0xA2,0xA3 on three consecutive cycles, req_ready constantly 1.
REQ-033 Read addr 7 (0xBEEF) with rsp_ready=0 for 4 cycles while req_addr changes -> state HOLD, req_ready=0, rsp_rdata stays 0xBEEF; a single response on rsp_ready=1.
REQ-034 Reset pulse during BYPASS -> rsp_valid=0 immediately, no response after release, txn_count=0.
REQ-035 Write accepted with MEM_REQ_CTRL_WRACK_EN defined -> one response with written data; same write without the macro -> no rsp_valid, busy stays 0.
REQ-036 65536 accepted requests from reset -> txn_count wraps to 0x0000.
